// File: rtl/iiitb_cg_ctrl.sv
// -----------------------------------------------------------------------------
// iiitb_cg_ctrl
// Upstream enable controller for an integrated clock-gating (ICG) cell.
// An idle-detect FSM runs on the free-running clock and watches the data bits
// of the gated register bank plus an explicit request line. After IDLE_CYCLES
// consecutive idle cycles it closes the gate. On activity it reopens the gate
// and keeps it open for a wake window of WAKE_CYCLES cycles.
//
// Parameters
//   IDLE_CYCLES : consecutive idle cycles before gating (>= 2)
//   WAKE_CYCLES : minimum cycles the gate stays open after a wake (>= 1)
//   CNT_W       : width of the saturating gate-entry counter
//
// Ports
//   clk      in   free-running clock (the clock the ICG gates)
//   rst      in   asynchronous active-high reset
//   d0, d1   in   watched data bits; a change counts as activity
//   req      in   level-sensitive activity request
//   force_on in   inhibits gating while high
//   en       out  ICG enable, driven straight from a flop (1 = clock runs)
//   gated    out  high while the FSM is in GATED (registered)
//   state    out  RUN=0, COUNT=1, GATED=2, WAKE=3
//   gate_cnt out  number of gate entries, saturating at all-ones
//
// Build option
//   CG_STATS_EN : when defined, gate_cnt counts gate entries; when undefined
//                 the counter is not built and gate_cnt is tied to 0.
// -----------------------------------------------------------------------------
module iiitb_cg_ctrl #(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d0,
  input  logic             d1,
  input  logic             req,
  input  logic             force_on,
  output logic             en,
  output logic             gated,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] gate_cnt
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES) + 1;
  localparam int WAKE_W = $clog2(WAKE_CYCLES) + 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    COUNT = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic              d0_q, d1_q;
  logic              en_q, gated_q;
  logic              act;

  // Any data edge on the watched bits, a request, or force_on is activity.
  assign act = req | force_on | (d0 ^ d0_q) | (d1 ^ d1_q);

  // Next-state and counter decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      RUN: begin
        if (act) begin
          idle_cnt_d = '0;
        end else begin
          state_d    = COUNT;
          idle_cnt_d = IDLE_W'(1);
        end
      end
      COUNT: begin
        // Activity on the terminal-count cycle wins: back to RUN, no entry.
        if (act) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = GATED;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      GATED: begin
        if (act) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        // The wake window is fixed length; activity here is ignored.
        if (wake_cnt_q == WAKE_LAST) begin
          state_d = RUN;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // en and gated are loaded from the next state so the ICG enable comes
  // straight off a flop and can never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      d0_q       <= 1'b0;
      d1_q       <= 1'b0;
      en_q       <= 1'b1;
      gated_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      d0_q       <= d0;
      d1_q       <= d1;
      en_q       <= (state_d != GATED);
      gated_q    <= (state_d == GATED);
    end
  end

`ifdef CG_STATS_EN
  logic [CNT_W-1:0] gate_cnt_q;
  logic             gate_entry;

  assign gate_entry = (state_q == COUNT) && (state_d == GATED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt_q <= '0;
    end else if (gate_entry && (gate_cnt_q != {CNT_W{1'b1}})) begin
      gate_cnt_q <= gate_cnt_q + CNT_W'(1);
    end
  end

  assign gate_cnt = gate_cnt_q;
`else
  assign gate_cnt = '0;
`endif

  assign en    = en_q;
  assign gated = gated_q;
  assign state = state_q;

endmodule

// File: tb/tb_iiitb_cg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iiitb_cg_ctrl
// Directed self-checking bench for iiitb_cg_ctrl with IDLE_CYCLES=4,
// WAKE_CYCLES=2, CNT_W=8. Expected gate counts follow CG_STATS_EN: with the
// macro undefined the counter output must read 0.
// -----------------------------------------------------------------------------
module tb_iiitb_cg_ctrl;

  localparam int CNT_W = 8;
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_GATED = 2'd2;
  localparam logic [1:0] S_WAKE  = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic             d0, d1, req, force_on;
  logic             en, gated;
  logic [1:0]       state;
  logic [CNT_W-1:0] gate_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  iiitb_cg_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2),
    .CNT_W      (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .d0      (d0),
    .d1      (d1),
    .req     (req),
    .force_on(force_on),
    .en      (en),
    .gated   (gated),
    .state   (state),
    .gate_cnt(gate_cnt)
  );

  always #5 clk = ~clk;

  // Expected gate_cnt after n gate entries since reset.
  function automatic logic [CNT_W-1:0] exp_gc(input int n);
`ifdef CG_STATS_EN
    return (n > 255) ? CNT_W'(255) : CNT_W'(n);
`else
    return CNT_W'(0);
`endif
  endfunction

  // Advance one edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    d0 = 1'b0; d1 = 1'b0; req = 1'b0; force_on = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    d0 = 1'b0; d1 = 1'b0; req = 1'b0; force_on = 1'b0;
    rst = 1'b1;
    #12;
    n_cmp++;
    if ({state, en, gated} !== {S_RUN, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: state=%0d en=%b gated=%b, want state=0 en=1 gated=0",
               state, en, gated);
    end
    n_cmp++;
    if (gate_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_gate_cnt: got %0d want 0", gate_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_idle_to_gate();
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++;
      if ({state, en, gated} !== {(i < 4) ? S_COUNT : S_GATED, (i < 4), (i == 4)}) begin
        n_bad++;
        $display("FAIL idle_edge%0d: state=%0d en=%b gated=%b, want state=%0d en=%b gated=%b",
                 i, state, en, gated, (i < 4) ? 1 : 2, (i < 4), (i == 4));
      end
    end
    n_cmp++;
    if (gate_cnt !== exp_gc(1)) begin
      n_bad++;
      $display("FAIL idle_gate_cnt: got %0d want %0d", gate_cnt, exp_gc(1));
    end
    // Staying idle keeps the gate closed.
    step(); step();
    n_cmp++;
    if ({state, en} !== {S_GATED, 1'b0}) begin
      n_bad++;
      $display("FAIL idle_hold: state=%0d en=%b, want state=2 en=0", state, en);
    end
  endtask

  // Activity on the terminal-count cycle must win over gating.
  task automatic test_abort_at_terminal();
    apply_reset();
    step(); step(); step();
    n_cmp++;
    if (state !== S_COUNT) begin
      n_bad++;
      $display("FAIL abort_pre: state=%0d want 1", state);
    end
    d0 = 1'b1;
    step();
    n_cmp++;
    if ({state, en, gated} !== {S_RUN, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_run: state=%0d en=%b gated=%b, want state=0 en=1 gated=0",
               state, en, gated);
    end
    n_cmp++;
    if (gate_cnt !== '0) begin
      n_bad++;
      $display("FAIL abort_gate_cnt: got %0d want 0", gate_cnt);
    end
    // d0 now static at 1: the sampled copy has caught up, so no activity.
    step();
    n_cmp++;
    if (state !== S_COUNT) begin
      n_bad++;
      $display("FAIL abort_static_d0: state=%0d want 1", state);
    end
    // A d1 edge is activity too.
    d1 = 1'b1;
    step();
    n_cmp++;
    if (state !== S_RUN) begin
      n_bad++;
      $display("FAIL abort_d1_edge: state=%0d want 0", state);
    end
  endtask

  task automatic test_wake();
    apply_reset();
    step(); step(); step(); step();
    n_cmp++;
    if (state !== S_GATED) begin
      n_bad++;
      $display("FAIL wake_pre: state=%0d want 2", state);
    end
    req = 1'b1;
    step();
    req = 1'b0;
    n_cmp++;
    if ({state, en, gated} !== {S_WAKE, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL wake_enter: state=%0d en=%b gated=%b, want state=3 en=1 gated=0",
               state, en, gated);
    end
    // Another request inside the window must not stretch it.
    req = 1'b1;
    step();
    req = 1'b0;
    n_cmp++;
    if ({state, en} !== {S_WAKE, 1'b1}) begin
      n_bad++;
      $display("FAIL wake_mid: state=%0d en=%b, want state=3 en=1", state, en);
    end
    step();
    n_cmp++;
    if ({state, en} !== {S_RUN, 1'b1}) begin
      n_bad++;
      $display("FAIL wake_exit: state=%0d en=%b, want state=0 en=1", state, en);
    end
    step();
    n_cmp++;
    if (state !== S_COUNT) begin
      n_bad++;
      $display("FAIL wake_recount: state=%0d want 1", state);
    end
  endtask

  task automatic test_force_on();
    apply_reset();
    force_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if ({state, en, gated} !== {S_RUN, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL force_cycle%0d: state=%0d en=%b gated=%b, want state=0 en=1 gated=0",
                 i, state, en, gated);
      end
    end
    n_cmp++;
    if (gate_cnt !== '0) begin
      n_bad++;
      $display("FAIL force_gate_cnt: got %0d want 0", gate_cnt);
    end
    force_on = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(); step(); step(); step();
    n_cmp++;
    if ({state, en, gate_cnt} !== {S_GATED, 1'b0, exp_gc(1)}) begin
      n_bad++;
      $display("FAIL areset_pre: state=%0d en=%b cnt=%0d, want state=2 en=0 cnt=%0d",
               state, en, gate_cnt, exp_gc(1));
    end
    // Mid-cycle: 3 ns after an edge, 7 ns before the next.
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({state, en, gated, gate_cnt} !== {S_RUN, 1'b1, 1'b0, CNT_W'(0)}) begin
      n_bad++;
      $display("FAIL areset_now: state=%0d en=%b gated=%b cnt=%0d, want state=0 en=1 gated=0 cnt=0",
               state, en, gated, gate_cnt);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int s = 0; s < 300; s++) begin
      step(); step(); step(); step();
      if (s == 0 || s == 254 || s == 255 || s == 299) begin
        n_cmp++;
        if ({state, gate_cnt} !== {S_GATED, exp_gc(s + 1)}) begin
          n_bad++;
          $display("FAIL sat_seq%0d: state=%0d cnt=%0d, want state=2 cnt=%0d",
                   s, state, gate_cnt, exp_gc(s + 1));
        end
      end
      req = 1'b1;
      step();
      req = 1'b0;
      step(); step();
    end
    n_cmp++;
    if ({state, gate_cnt} !== {S_RUN, exp_gc(300)}) begin
      n_bad++;
      $display("FAIL sat_final: state=%0d cnt=%0d, want state=0 cnt=%0d",
               state, gate_cnt, exp_gc(300));
    end
  endtask

  initial begin
    test_reset();
    test_idle_to_gate();
    test_abort_at_terminal();
    test_wake();
    test_force_on();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
